// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving a shared mux key and one-hot grant with a valid/ready handshake.
// Optional burst locking is enabled by defining MUX_SCHED_LOCK_EN.
module mux_rr_sched #(
  parameter int NR_REQ    = 4,
  parameter int KEY_LEN   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NR_REQ-1:0]  req,
  input  logic [NR_REQ-1:0]  lock,
  output logic [KEY_LEN-1:0] key,
  output logic [NR_REQ-1:0]  gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int IDX_W = $clog2(NR_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   g, g_n;
  logic [IDX_W-1:0]   ptr_rel, scan_base, win;
  logic [KEY_LEN-1:0] key_n;
  logic [NR_REQ-1:0]  gnt_n;
  logic               valid_n, hs, found, keep, beat_inc, beat_clr;

  // First requester at or after base, wrapping modulo NR_REQ; MSB flags a hit.
  function automatic logic [IDX_W:0] pick(input logic [NR_REQ-1:0] r,
                                          input logic [IDX_W-1:0] base);
    logic             hit;
    logic [IDX_W-1:0] idx;
    int               j;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      j = (int'(base) + i) % NR_REQ;
      if (!hit && r[j]) begin
        hit = 1'b1;
        idx = IDX_W'(j);
      end
    end
    return {hit, idx};
  endfunction

  assign hs        = out_valid & out_ready;
  assign ptr_rel   = (g == IDX_W'(NR_REQ - 1)) ? '0 : g + 1'b1;
  assign scan_base = (state == BUSY) ? ptr_rel : ptr;
  assign {found, win} = pick(req, scan_base);

`ifdef MUX_SCHED_LOCK_EN
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BW-1:0] beat_cnt;

  assign keep = lock[g] & req[g] & (int'(beat_cnt) < MAX_BURST - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        beat_cnt <= '0;
    else if (beat_clr) beat_cnt <= '0;
    else if (beat_inc) beat_cnt <= beat_cnt + 1'b1;
  end
`else
  logic unused_lock;
  logic unused_beat;
  assign keep        = 1'b0;
  assign unused_lock = ^lock;
  assign unused_beat = beat_inc | beat_clr;
`endif

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    g_n      = g;
    key_n    = key;
    gnt_n    = gnt;
    valid_n  = out_valid;
    beat_inc = 1'b0;
    beat_clr = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = BUSY;
          g_n      = win;
          key_n    = KEY_LEN'(win);
          gnt_n    = NR_REQ'(1) << win;
          valid_n  = 1'b1;
          beat_clr = 1'b1;
        end
      end
      BUSY: begin
        if (hs) begin
          if (keep) begin
            beat_inc = 1'b1;
          end else begin
            // Released grant: rescan from the slot after it, same cycle.
            ptr_n    = ptr_rel;
            beat_clr = 1'b1;
            if (found) begin
              g_n     = win;
              key_n   = KEY_LEN'(win);
              gnt_n   = NR_REQ'(1) << win;
              valid_n = 1'b1;
            end else begin
              state_n = IDLE;
              key_n   = '0;
              gnt_n   = '0;
              valid_n = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      key       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      g         <= g_n;
      key       <= key_n;
      gnt       <= gnt_n;
      out_valid <= valid_n;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed testbench for mux_rr_sched; expected keys follow MUX_SCHED_LOCK_EN when defined.
module tb_mux_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [1:0] key;
  logic [3:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_cmp;
  int n_err;

  mux_rr_sched #(.NR_REQ(4), .KEY_LEN(2), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .key       (key),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the rising edge for sampling and driving.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    req       = r;
    lock      = l;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] ek, input logic [3:0] eg,
                             input logic ev, input logic eb);
    n_cmp++;
    assert (key === ek) else begin
      n_err++;
      $error("[TB] FAIL %s key: observed %0d expected %0d", tag, key, ek);
    end
    n_cmp++;
    assert (gnt === eg) else begin
      n_err++;
      $error("[TB] FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
    end
    n_cmp++;
    assert (out_valid === ev) else begin
      n_err++;
      $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, out_valid, ev);
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_err++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, eb);
    end
  endtask

  logic [1:0] lock_keys [5];
  logic [1:0] exp_k;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req       = '0;
    lock      = '0;
    out_ready = 1'b0;
`ifdef MUX_SCHED_LOCK_EN
    lock_keys = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
`else
    lock_keys = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif

    #3;
    checkOutput("reset_init", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_ready_no_req", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Full round robin from ptr=0.
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("rr_k0", 2'd0, 4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("rr_k1", 2'd1, 4'b0010, 1'b1, 1'b1);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("rr_k2", 2'd2, 4'b0100, 1'b1, 1'b1);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("rr_k3", 2'd3, 4'b1000, 1'b1, 1'b1);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("rr_wrap_k0", 2'd0, 4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("rr_idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Single requester re-granted every cycle with no bubble; ptr ends at 3.
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkOutput("single_first", 2'd2, 4'b0100, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checkOutput("single_regrant", 2'd2, 4'b0100, 1'b1, 1'b1);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("single_idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Wrap from ptr=3 to 0, then idle.
    applyStimulus(4'b1001, 4'b0000, 1'b1);
    checkOutput("wrap_k3", 2'd3, 4'b1000, 1'b1, 1'b1);
    applyStimulus(4'b1001, 4'b0000, 1'b1);
    checkOutput("wrap_k0", 2'd0, 4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("wrap_idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // ptr=1: grant requester 1, hold it, then reset asynchronously mid-BUSY.
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    checkOutput("pre_reset_busy", 2'd1, 4'b0010, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure from ptr=0: grant held while out_ready is low.
    applyStimulus(4'b0011, 4'b0000, 1'b0);
    checkOutput("bp_first", 2'd0, 4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, 4'b0000, 1'b0);
      checkOutput("bp_hold", 2'd0, 4'b0001, 1'b1, 1'b1);
    end
    // Dropping req before the handshake must not release the grant.
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    checkOutput("bp_req_drop", 2'd0, 4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    checkOutput("bp_release_k1", 2'd1, 4'b0010, 1'b1, 1'b1);

    // Burst lock on requester 0 (ignored without the lock build).
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, 4'b0001, 1'b1);
      exp_k = lock_keys[i];
      checkOutput("lock_seq", exp_k, 4'b0001 << exp_k, 1'b1, 1'b1);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("final_idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
